// File: rtl/bist_pkg.sv
// Shared types and default constants for the BIST controller and its pattern counter.
package bist_pkg;

   localparam int              DEF_N_PATTERNS = 7;
   localparam int              DEF_CNT_W      = 3;
   localparam int              DEF_SIG_W      = 3;
   localparam int              DEF_PIPE_LAT   = 1;
   localparam logic [2:0]      DEF_GOLDEN_SIG = 3'b101;
   localparam int              FLUSH_W        = 3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_INIT    = 3'd1,
      ST_RUN     = 3'd2,
      ST_FLUSH   = 3'd3,
      ST_COMPARE = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   typedef struct packed {
      logic lfsr_rst;
      logic lfsr_en;
      logic misr_clr;
      logic misr_en;
      logic test_mode;
      logic busy;
   } ctl_t;

   // Moore decode of the LFSR/MISR control strobes from the FSM state.
   function automatic ctl_t decode_ctl(input state_t s);
      ctl_t c;
      c = '0;
      case (s)
         ST_IDLE:    c.lfsr_rst = 1'b1;
         ST_INIT: begin
            c.lfsr_rst  = 1'b1;
            c.misr_clr  = 1'b1;
            c.test_mode = 1'b1;
            c.busy      = 1'b1;
         end
         ST_RUN: begin
            c.lfsr_en   = 1'b1;
            c.misr_en   = 1'b1;
            c.test_mode = 1'b1;
            c.busy      = 1'b1;
         end
         ST_FLUSH: begin
            c.misr_en   = 1'b1;
            c.test_mode = 1'b1;
            c.busy      = 1'b1;
         end
         ST_COMPARE: begin
            c.test_mode = 1'b1;
            c.busy      = 1'b1;
         end
         ST_DONE:    c.lfsr_rst = 1'b1;
         default:    c.lfsr_rst = 1'b1;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/bist_pat_counter.sv
// Pattern counter: synchronous clear, saturating increment, terminal-count flag.
module bist_pat_counter
   import bist_pkg::*;
#(
   parameter int CNT_W      = DEF_CNT_W,
   parameter int N_PATTERNS = DEF_N_PATTERNS
)(
   input  logic             clock,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic             tc
);

   assign tc = (count == CNT_W'(N_PATTERNS - 1));

   // Increment is gated by tc so the count can never wrap.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en && !tc)
         count <= count + 1'b1;
   end

endmodule

// File: rtl/bist_controller.sv
// BIST sequencer: drives LFSR/MISR through init, run, flush and compare, then reports pass/fail.
module bist_controller
   import bist_pkg::*;
#(
   parameter int              N_PATTERNS = DEF_N_PATTERNS,
   parameter int              CNT_W      = DEF_CNT_W,
   parameter int              SIG_W      = DEF_SIG_W,
   parameter int              PIPE_LAT   = DEF_PIPE_LAT,
   parameter logic [SIG_W-1:0] GOLDEN_SIG = SIG_W'(DEF_GOLDEN_SIG)
)(
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             lfsr_complete,
   input  logic [SIG_W-1:0] misr_sig,
   output logic             lfsr_rst,
   output logic             lfsr_en,
   output logic             misr_clr,
   output logic             misr_en,
   output logic             test_mode,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] pat_count
);

   state_t             state, state_nxt;
   ctl_t               ctl;
   logic [FLUSH_W-1:0] flush_cnt;
   logic               pass_q;
   logic               tc;
   logic               run_exit;
   logic               flush_last;
   logic               start_acc;
   logic               cnt_clr;
   logic               cnt_en;

   assign run_exit   = tc | lfsr_complete;
   assign flush_last = ((int'(flush_cnt) + 1) == PIPE_LAT);
   assign start_acc  = start && !abort && (state == ST_IDLE || state == ST_DONE);
   assign cnt_clr    = abort | start_acc | (state == ST_INIT);
   assign cnt_en     = (state == ST_RUN) && !run_exit;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ctl       = decode_ctl(state);
      if (abort) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:    if (start) state_nxt = ST_INIT;
            ST_INIT:    state_nxt = ST_RUN;
            ST_RUN:     if (run_exit) state_nxt = (PIPE_LAT == 0) ? ST_COMPARE : ST_FLUSH;
            ST_FLUSH:   if (flush_last) state_nxt = ST_COMPARE;
            ST_COMPARE: state_nxt = ST_DONE;
            ST_DONE:    if (start) state_nxt = ST_INIT;
            default:    state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         flush_cnt <= '0;
      else if (state == ST_FLUSH && !flush_last && !abort)
         flush_cnt <= flush_cnt + 1'b1;
      else
         flush_cnt <= '0;
   end

   // Verdict is captured as COMPARE exits and held through DONE.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         pass_q <= 1'b0;
      else if (abort || start_acc)
         pass_q <= 1'b0;
      else if (state == ST_COMPARE)
         pass_q <= (misr_sig == GOLDEN_SIG);
   end

   bist_pat_counter #(
      .CNT_W      (CNT_W),
      .N_PATTERNS (N_PATTERNS)
   ) u_pat_counter (
      .clock (clock),
      .reset (reset),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .count (pat_count),
      .tc    (tc)
   );

   assign lfsr_rst  = ctl.lfsr_rst;
   assign lfsr_en   = ctl.lfsr_en;
   assign misr_clr  = ctl.misr_clr;
   assign misr_en   = ctl.misr_en;
   assign test_mode = ctl.test_mode;
   assign busy      = ctl.busy;
   assign done      = (state == ST_DONE);
   assign pass      = pass_q;

endmodule

// File: tb/tb_bist_controller.sv
// Scoreboarded random test of bist_controller against a run-level timing/verdict model.
module tb_bist_controller;

   localparam int         N_PAT = 7;
   localparam int         PL    = 1;
   localparam logic [2:0] GOLD  = 3'b101;

   logic       clock = 1'b0;
   logic       reset, start, abort, lfsr_complete;
   logic [2:0] misr_sig;
   logic       lfsr_rst, lfsr_en, misr_clr, misr_en, test_mode, busy, done, pass;
   logic [2:0] pat_count;

   typedef struct {
      int   se;
      logic pass;
      int   pc;
      int   lat;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   bist_controller dut (
      .clock(clock), .reset(reset), .start(start), .abort(abort),
      .lfsr_complete(lfsr_complete), .misr_sig(misr_sig),
      .lfsr_rst(lfsr_rst), .lfsr_en(lfsr_en), .misr_clr(misr_clr), .misr_en(misr_en),
      .test_mode(test_mode), .busy(busy), .done(done), .pass(pass), .pat_count(pat_count)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Run-level model: patterns applied, then flush, compare, done.
   function automatic exp_t model(input logic [2:0] sig, input int k);
      exp_t e;
      e.pc   = (k >= 0 && k < N_PAT - 1) ? k : N_PAT - 1;
      e.lat  = 1 + (e.pc + 1) + PL + 1;
      e.pass = (sig == GOLD);
      e.se   = 0;
      return e;
   endfunction

   initial begin : monitor
      logic done_d;
      exp_t e;
      done_d = 1'b0;
      forever begin
         @(negedge clock);
         if (done && !done_d) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               e = q.pop_front();
               chk("sb_pass", int'(pass), int'(e.pass));
               chk("sb_pat_count", int'(pat_count), e.pc);
               chk("sb_latency", cyc - e.se, e.lat);
            end
         end
         done_d = done;
      end
   end

   task automatic run_test(input logic [2:0] sig, input int k, input bit use_ign);
      exp_t e;
      int   ign;
      e   = model(sig, k);
      ign = use_ign ? 2 + int'($urandom % 32'(e.lat - 1)) : 0;
      misr_sig = sig;
      start    = 1'b1;
      e.se     = cyc + 1;
      q.push_back(e);
      tick();
      start = 1'b0;
      for (int t = 1; t <= 40 && q.size() != 0; t++) begin
         if (t == 1) begin
            chk("init_misr_clr", int'(misr_clr), 1);
            chk("init_lfsr_rst", int'(lfsr_rst), 1);
            chk("init_busy", int'(busy), 1);
         end
         if (t == 2) begin
            chk("run_lfsr_en", int'(lfsr_en), 1);
            chk("run_misr_en", int'(misr_en), 1);
            chk("run_test_mode", int'(test_mode), 1);
            chk("run_pat_count0", int'(pat_count), 0);
         end
         lfsr_complete = (k >= 0 && t == k + 2);
         start         = (t == ign);
         tick();
      end
      start         = 1'b0;
      lfsr_complete = 1'b0;
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=0 required=1");
         q.delete();
      end
      chk("done_hold", int'(done), 1);
      chk("done_busy", int'(busy), 0);
      chk("done_lfsr_rst", int'(lfsr_rst), 1);
      chk("done_pass", int'(pass), int'(e.pass));
   endtask

   task automatic abort_test(input int at);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (1 + at) tick();
      chk("pre_abort_pc", int'(pat_count), at);
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_pass", int'(pass), 0);
      chk("abort_pc", int'(pat_count), 0);
      chk("abort_lfsr_rst", int'(lfsr_rst), 1);
      tick();
      chk("abort_start_ignored", int'(busy), 0);
   endtask

   initial begin : stim
      exp_t e;
      int   base;
      reset = 1'b0; start = 1'b0; abort = 1'b0; lfsr_complete = 1'b0; misr_sig = 3'b000;
      #8;
      chk("rst_lfsr_rst", int'(lfsr_rst), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_pass", int'(pass), 0);
      chk("rst_pc", int'(pat_count), 0);
      chk("rst_strobes", int'({lfsr_en, misr_clr, misr_en, test_mode}), 0);
      #2 reset = 1'b1;
      tick();

      run_test(3'b101, -1, 1'b0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("done_abort_done", int'(done), 0);
      chk("done_abort_pass", int'(pass), 0);
      run_test(3'b011, -1, 1'b0);
      run_test(3'b101, 3, 1'b0);
      run_test(3'b101, -1, 1'b1);
      abort_test(4);
      run_test(3'b101, -1, 1'b0);

      // Reset asserted while flushing.
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (8) tick();
      chk("flush_misr_en", int'(misr_en), 1);
      chk("flush_lfsr_en", int'(lfsr_en), 0);
      chk("flush_pc", int'(pat_count), N_PAT - 1);
      #1 reset = 1'b0;
      #1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_lfsr_rst", int'(lfsr_rst), 1);
      chk("midrst_pc", int'(pat_count), 0);
      chk("midrst_done", int'(done), 0);
      #1 reset = 1'b1;
      tick();
      chk("midrst_idle", int'(busy), 0);

      // Start held high: three back-to-back runs.
      misr_sig = GOLD;
      e        = model(GOLD, -1);
      start    = 1'b1;
      base     = cyc + 1;
      for (int i = 0; i < 3; i++) begin
         e.se = base + i * (e.lat + 1);
         q.push_back(e);
      end
      repeat (2 * (e.lat + 1) + 1) tick();
      start = 1'b0;
      for (int t = 0; t < 30 && q.size() != 0; t++) tick();
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL b2b_timeout actual=%0d required=0", q.size());
         q.delete();
      end

      for (int i = 0; i < 24; i++) begin
         logic [2:0] sig;
         int         k;
         repeat ($urandom % 3) tick();
         if ($urandom % 6 == 0) begin
            abort_test(int'($urandom % (N_PAT - 1)));
         end else begin
            sig = ($urandom % 2 == 0) ? GOLD : 3'($urandom);
            k   = ($urandom % 3 == 0) ? int'($urandom % N_PAT) : -1;
            run_test(sig, k, 1'($urandom % 2));
         end
      end

      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
